// File: rtl/lcd_rx_decoder.sv
// Receiver for a character-LCD write bus: synchronizes the asynchronous pins, commits
// each transaction on the en falling edge and models a 32-cell display RAM plus controller state.
module lcd_rx_decoder #(
    parameter int CMD_CYC = 8,
    parameter int CLR_CYC = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rs,
    input  logic       rw,
    input  logic       en,
    input  logic [7:0] dat,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [4:0] ac,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink,
    output logic       incr,
    output logic       busy,
    output logic       cmd_stb,
    output logic       chr_stb,
    output logic       frame_done,
    output logic       err
);
    localparam int MAXC = (CLR_CYC > CMD_CYC) ? CLR_CYC : CMD_CYC;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] CMD_LD  = CW'(CMD_CYC - 1);
    localparam logic [CW-1:0] CLR_LD  = CW'(CLR_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {IDLE, BUSY, BUSY_CLR} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       rs_sq, rw_sq;
    logic [2:0]       en_sq;
    logic [7:0]       dat_s1_q, dat_s2_q;
    logic             hrs_q, hrw_q;
    logic [7:0]       hdat_q;
    logic [31:0][7:0] cells_q, cells_d;
    logic [4:0]       ac_q, ac_d, step;
    logic             disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
    logic             incr_q, incr_d, err_q, err_d;
    logic             cmd_stb_q, cmd_stb_d, chr_stb_q, chr_stb_d, fd_q, fd_d;
    logic [7:0]       rd_data_q;
    logic             fall;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rs_sq    <= '0;
            rw_sq    <= '0;
            en_sq    <= '0;
            dat_s1_q <= '0;
            dat_s2_q <= '0;
            hrs_q    <= 1'b0;
            hrw_q    <= 1'b0;
            hdat_q   <= '0;
        end else begin
            rs_sq    <= {rs_sq[0], rs};
            rw_sq    <= {rw_sq[0], rw};
            en_sq    <= {en_sq[1:0], en};
            dat_s1_q <= dat;
            dat_s2_q <= dat_s1_q;
            // Bus fields captured while en is still high, consumed at the fall.
            if (en_sq[1]) begin
                hrs_q  <= rs_sq[1];
                hrw_q  <= rw_sq[1];
                hdat_q <= dat_s2_q;
            end
        end
    end

    assign fall = en_sq[2] & ~en_sq[1];
    assign step = incr_q ? 5'd1 : 5'd31;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cells_d   = cells_q;
        ac_d      = ac_q;
        disp_d    = disp_q;
        cur_d     = cur_q;
        blink_d   = blink_q;
        incr_d    = incr_q;
        err_d     = err_q;
        cmd_stb_d = 1'b0;
        chr_stb_d = 1'b0;
        fd_d      = 1'b0;

        if (state_q != IDLE) begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - CNT_ONE;
        end

        // A fall in the counter's final cycle still sees busy and is rejected.
        if (fall && !hrw_q) begin
            if (state_q != IDLE) begin
                err_d = 1'b1;
            end else if (hrs_q) begin
                cells_d[ac_q] = hdat_q;
                ac_d          = ac_q + step;
                chr_stb_d     = 1'b1;
                fd_d          = (ac_q == 5'd31);
                state_d       = BUSY;
                cnt_d         = CMD_LD;
            end else if (hdat_q != 8'h00) begin
                cmd_stb_d = 1'b1;
                state_d   = BUSY;
                cnt_d     = CMD_LD;
                if (hdat_q[7]) begin
                    ac_d = {hdat_q[6], hdat_q[3:0]};
                end else if (hdat_q[6]) begin
                    err_d = 1'b1;
                end else if (hdat_q[5]) begin
                    if (!hdat_q[4]) err_d = 1'b1;
                end else if (hdat_q[4]) begin
                    if (!hdat_q[3]) ac_d = hdat_q[2] ? ac_q + 5'd1 : ac_q - 5'd1;
                end else if (hdat_q[3]) begin
                    disp_d  = hdat_q[2];
                    cur_d   = hdat_q[1];
                    blink_d = hdat_q[0];
                end else if (hdat_q[2]) begin
                    incr_d = hdat_q[1];
                end else if (hdat_q[1]) begin
                    ac_d = 5'd0;
                end else begin
                    cells_d = {32{8'h20}};
                    ac_d    = 5'd0;
                    incr_d  = 1'b1;
                    state_d = BUSY_CLR;
                    cnt_d   = CLR_LD;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cells_q   <= {32{8'h20}};
            ac_q      <= '0;
            disp_q    <= 1'b0;
            cur_q     <= 1'b0;
            blink_q   <= 1'b0;
            incr_q    <= 1'b1;
            err_q     <= 1'b0;
            cmd_stb_q <= 1'b0;
            chr_stb_q <= 1'b0;
            fd_q      <= 1'b0;
            rd_data_q <= 8'h20;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cells_q   <= cells_d;
            ac_q      <= ac_d;
            disp_q    <= disp_d;
            cur_q     <= cur_d;
            blink_q   <= blink_d;
            incr_q    <= incr_d;
            err_q     <= err_d;
            cmd_stb_q <= cmd_stb_d;
            chr_stb_q <= chr_stb_d;
            fd_q      <= fd_d;
            rd_data_q <= cells_q[rd_addr];
        end
    end

    assign rd_data    = rd_data_q;
    assign ac         = ac_q;
    assign disp_on    = disp_q;
    assign cursor_on  = cur_q;
    assign blink      = blink_q;
    assign incr       = incr_q;
    assign busy       = (state_q != IDLE);
    assign cmd_stb    = cmd_stb_q;
    assign chr_stb    = chr_stb_q;
    assign frame_done = fd_q;
    assign err        = err_q;

endmodule

// File: tb/tb_lcd_rx_decoder.sv
// Bench for lcd_rx_decoder: a vector table of bus transactions with a strobe scoreboard,
// followed by hand-built sequences for busy-window, reset-abort and boundary cases.
module tb_lcd_rx_decoder;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rs = 1'b0, rw = 1'b0, en = 1'b0;
    logic [7:0] dat = 8'h00;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] rd_data;
    logic [4:0] ac;
    logic       disp_on, cursor_on, blink, incr, busy, cmd_stb, chr_stb, frame_done, err;

    always #5 clk = ~clk;

    lcd_rx_decoder #(.CMD_CYC(8), .CLR_CYC(32)) dut (
        .clk(clk), .reset_n(reset_n), .rs(rs), .rw(rw), .en(en), .dat(dat),
        .rd_addr(rd_addr), .rd_data(rd_data), .ac(ac), .disp_on(disp_on),
        .cursor_on(cursor_on), .blink(blink), .incr(incr), .busy(busy),
        .cmd_stb(cmd_stb), .chr_stb(chr_stb), .frame_done(frame_done), .err(err)
    );

    typedef struct {
        logic       cmd;
        logic       chr;
        logic       fd;
        logic [4:0] ac;
    } exp_t;

    typedef struct {
        logic       rs;
        logic       rw;
        logic [7:0] d;
        logic [4:0] ac;
        logic [4:0] fl;   // {disp_on, cursor_on, blink, incr, err}
        logic       cmd;
        logic       chr;
        logic       fd;
        int         bcyc;
    } vec_t;

    exp_t       sbq[$];
    vec_t       tbl[$];
    vec_t       v;
    exp_t       e;
    int         n_cmp = 0, n_bad = 0;
    int         stb_at, bcnt;
    logic [7:0] exp_cells [32];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic c, input logic ch, input logic fd, input logic [4:0] a);
        exp_t t;
        t.cmd = c; t.chr = ch; t.fd = fd; t.ac = a;
        sbq.push_back(t);
    endtask

    task automatic add(input logic r, input logic w, input logic [7:0] d, input logic [4:0] a,
                       input logic [4:0] f, input logic c, input logic ch, input logic fd,
                       input int b);
        vec_t t;
        t.rs = r; t.rw = w; t.d = d; t.ac = a; t.fl = f;
        t.cmd = c; t.chr = ch; t.fd = fd; t.bcyc = b;
        tbl.push_back(t);
    endtask

    // Returns at the negedge where en was dropped.
    task automatic drive(input logic r, input logic w, input logic [7:0] d, input int hi);
        @(negedge clk); rs = r; rw = w; dat = d;
        repeat (2) @(negedge clk);
        en = 1'b1;
        repeat (hi) @(negedge clk);
        en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
    endtask

    task automatic rd_chk(input int idx, input logic [7:0] exp);
        @(negedge clk); rd_addr = 5'(idx);
        @(negedge clk);
        chk($sformatf("cell%0d", idx), 32'(rd_data), 32'(exp));
    endtask

    // Scoreboard: every strobe must match the next expected transaction.
    always @(negedge clk) begin
        if (cmd_stb || chr_stb || frame_done) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: got cmd=%0b chr=%0b fd=%0b want none",
                         cmd_stb, chr_stb, frame_done);
            end else begin
                e = sbq.pop_front();
                chk("sb_strobe", 32'({cmd_stb, chr_stb, frame_done}), 32'({e.cmd, e.chr, e.fd}));
                chk("sb_ac", 32'(ac), 32'(e.ac));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        //   rs rw dat    ac     flags     cmd chr fd busy
        add(0, 0, 8'h38, 5'd0,  5'b00010, 1, 0, 0, 8);
        add(0, 0, 8'h0C, 5'd0,  5'b10010, 1, 0, 0, 8);
        add(0, 0, 8'h06, 5'd0,  5'b10010, 1, 0, 0, 8);
        add(0, 0, 8'h01, 5'd0,  5'b10010, 1, 0, 0, 32);
        add(1, 0, 8'h76, 5'd1,  5'b10010, 0, 1, 0, 8);
        add(1, 0, 8'h65, 5'd2,  5'b10010, 0, 1, 0, 8);
        add(1, 0, 8'h6C, 5'd3,  5'b10010, 0, 1, 0, 8);
        add(1, 0, 8'h6F, 5'd4,  5'b10010, 0, 1, 0, 8);
        add(1, 0, 8'h3A, 5'd5,  5'b10010, 0, 1, 0, 8);
        add(0, 0, 8'h8F, 5'd15, 5'b10010, 1, 0, 0, 8);
        add(1, 0, 8'h41, 5'd16, 5'b10010, 0, 1, 0, 8);
        add(1, 0, 8'h42, 5'd17, 5'b10010, 0, 1, 0, 8);
        add(0, 0, 8'hDF, 5'd31, 5'b10010, 1, 0, 0, 8);
        add(1, 0, 8'h5A, 5'd0,  5'b10010, 0, 1, 1, 8);
        add(0, 0, 8'h10, 5'd31, 5'b10010, 1, 0, 0, 8);
        add(0, 0, 8'h14, 5'd0,  5'b10010, 1, 0, 0, 8);
        add(0, 0, 8'h18, 5'd0,  5'b10010, 1, 0, 0, 8);
        add(0, 0, 8'h04, 5'd0,  5'b10000, 1, 0, 0, 8);
        add(0, 0, 8'h80, 5'd0,  5'b10000, 1, 0, 0, 8);
        add(1, 0, 8'h78, 5'd31, 5'b10000, 0, 1, 0, 8);
        add(0, 1, 8'h01, 5'd31, 5'b10000, 0, 0, 0, 0);
        add(1, 1, 8'h55, 5'd31, 5'b10000, 0, 0, 0, 0);
        add(0, 0, 8'h0F, 5'd31, 5'b11100, 1, 0, 0, 8);
        add(0, 0, 8'h00, 5'd31, 5'b11100, 0, 0, 0, 0);
        add(0, 0, 8'h02, 5'd0,  5'b11100, 1, 0, 0, 8);
        add(0, 0, 8'h07, 5'd0,  5'b11110, 1, 0, 0, 8);
        add(0, 0, 8'h3C, 5'd0,  5'b11110, 1, 0, 0, 8);
        add(0, 0, 8'h28, 5'd0,  5'b11111, 1, 0, 0, 8);

        for (int i = 0; i < 32; i++) exp_cells[i] = 8'h20;
        exp_cells[0]  = 8'h78;
        exp_cells[1]  = 8'h65;
        exp_cells[2]  = 8'h6C;
        exp_cells[3]  = 8'h6F;
        exp_cells[4]  = 8'h3A;
        exp_cells[15] = 8'h41;
        exp_cells[16] = 8'h42;
        exp_cells[31] = 8'h5A;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ac", 32'(ac), 32'd0);
        chk("rst_flags", 32'({disp_on, cursor_on, blink, incr, err}), 32'b00010);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_strobes", 32'({cmd_stb, chr_stb, frame_done}), 32'd0);
        rd_chk(0, 8'h20);
        rd_chk(31, 8'h20);

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            if (v.cmd || v.chr) push(v.cmd, v.chr, v.fd, v.ac);
            drive(v.rs, v.rw, v.d, 20);
            stb_at = 0;
            bcnt   = 0;
            for (int k = 1; k <= 60; k++) begin
                @(negedge clk);
                if (cmd_stb || chr_stb) stb_at = k;
                if (busy) bcnt++;
            end
            chk($sformatf("v%0d_stb_at", i), 32'(stb_at), (v.cmd || v.chr) ? 32'd3 : 32'd0);
            chk($sformatf("v%0d_busy_cyc", i), 32'(bcnt), 32'(v.bcyc));
            chk($sformatf("v%0d_ac", i), 32'(ac), 32'(v.ac));
            chk($sformatf("v%0d_flags", i), 32'({disp_on, cursor_on, blink, incr, err}), 32'(v.fl));
        end

        for (int i = 0; i < 32; i++) rd_chk(i, exp_cells[i]);

        // Data write landing inside the clear busy window.
        do_reset();
        push(1, 0, 0, 5'd0);
        drive(0, 0, 8'h01, 20);
        drive(1, 0, 8'h51, 4);
        repeat (40) @(negedge clk);
        chk("clrbusy_err", 32'(err), 32'd1);
        chk("clrbusy_ac", 32'(ac), 32'd0);
        rd_chk(0, 8'h20);
        push(1, 0, 0, 5'd0);
        drive(0, 0, 8'h0C, 20);
        repeat (20) @(negedge clk);
        chk("err_sticky", 32'(err), 32'd1);
        chk("err_sticky_disp", 32'(disp_on), 32'd1);

        // CGRAM address is flagged.
        do_reset();
        chk("rst_err_clear", 32'(err), 32'd0);
        push(1, 0, 0, 5'd0);
        drive(0, 0, 8'h40, 20);
        repeat (20) @(negedge clk);
        chk("cgram_err", 32'(err), 32'd1);

        // Fall coinciding with the last busy cycle is rejected.
        do_reset();
        push(1, 0, 0, 5'd0);
        drive(0, 0, 8'h0C, 20);
        drive(0, 0, 8'h0E, 5);
        repeat (20) @(negedge clk);
        chk("edge_rej_err", 32'(err), 32'd1);
        chk("edge_rej_cur", 32'(cursor_on), 32'd0);

        // One cycle later it is accepted.
        do_reset();
        push(1, 0, 0, 5'd0);
        drive(0, 0, 8'h0C, 20);
        push(1, 0, 0, 5'd0);
        drive(0, 0, 8'h0E, 6);
        repeat (20) @(negedge clk);
        chk("edge_acc_err", 32'(err), 32'd0);
        chk("edge_acc_cur", 32'(cursor_on), 32'd1);

        // Reset while busy after a data write.
        do_reset();
        push(0, 1, 0, 5'd1);
        drive(1, 0, 8'h79, 20);
        repeat (5) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        chk("rstbusy_busy", 32'(busy), 32'd0);
        chk("rstbusy_ac", 32'(ac), 32'd0);
        rd_chk(0, 8'h20);

        // Reset between en fall and commit aborts with en already low afterwards.
        drive(1, 0, 8'h71, 20);
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ac", 32'(ac), 32'd0);
        rd_chk(0, 8'h20);

        repeat (4) @(negedge clk);
        chk("sb_drain", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
